// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 stream demultiplexer.
// One valid/ready input stream is steered word by word to output A or B
// according to sel. Each output has its own one-entry holding slot, so the
// two outputs drain independently and a stalled output never blocks the
// other. Each output also has a wrapping transfer counter for bring-up/debug.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   din       input data word (n bits)
//   sel       destination of din: 0 -> A, 1 -> B
//   in_valid  din/sel valid this cycle
//   in_ready  block accepts din this cycle (combinational)
//   douta     output A data (registered)
//   va        output A holds a valid word
//   a_ready   A consumer accepts this cycle
//   doutb     output B data (registered)
//   vb        output B holds a valid word
//   b_ready   B consumer accepts this cycle
//   cnt_a     completed A transfers, modulo 2^cw
//   cnt_b     completed B transfers, modulo 2^cw
module demux_stream #(
    parameter int n  = 4,
    parameter int cw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [n-1:0]  din,
    input  logic          sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [n-1:0]  douta,
    output logic          va,
    input  logic          a_ready,
    output logic [n-1:0]  doutb,
    output logic          vb,
    input  logic          b_ready,
    output logic [cw-1:0] cnt_a,
    output logic [cw-1:0] cnt_b
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t   state_a_r, state_a_next_s;
    slot_state_t   state_b_r, state_b_next_s;
    logic [n-1:0]  douta_r, doutb_r;
    logic [cw-1:0] cnt_a_r, cnt_b_r;

    logic free_a_s, free_b_s;
    logic acc_a_s, acc_b_s;
    logic drain_a_s, drain_b_s;
    logic in_ready_s;

    // Handshake decode: a slot is free when empty or draining this cycle.
    // in_ready deliberately ignores in_valid so upstream can't form a loop.
    always_comb begin
        free_a_s   = 1'b0;
        free_b_s   = 1'b0;
        in_ready_s = 1'b0;
        acc_a_s    = 1'b0;
        acc_b_s    = 1'b0;
        drain_a_s  = 1'b0;
        drain_b_s  = 1'b0;

        free_a_s   = (state_a_r == SLOT_EMPTY) | a_ready;
        free_b_s   = (state_b_r == SLOT_EMPTY) | b_ready;
        in_ready_s = sel ? free_b_s : free_a_s;
        acc_a_s    = in_valid & in_ready_s & ~sel;
        acc_b_s    = in_valid & in_ready_s & sel;
        drain_a_s  = (state_a_r == SLOT_FULL) & a_ready;
        drain_b_s  = (state_b_r == SLOT_FULL) & b_ready;
    end

    // Next-state logic for both slots; an accept keeps a draining slot full.
    always_comb begin
        state_a_next_s = state_a_r;
        state_b_next_s = state_b_r;

        case (state_a_r)
            SLOT_EMPTY: begin
                if (acc_a_s) begin
                    state_a_next_s = SLOT_FULL;
                end else begin
                    state_a_next_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (acc_a_s) begin
                    state_a_next_s = SLOT_FULL;
                end else if (a_ready) begin
                    state_a_next_s = SLOT_EMPTY;
                end else begin
                    state_a_next_s = SLOT_FULL;
                end
            end
            default: state_a_next_s = SLOT_EMPTY;
        endcase

        case (state_b_r)
            SLOT_EMPTY: begin
                if (acc_b_s) begin
                    state_b_next_s = SLOT_FULL;
                end else begin
                    state_b_next_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (acc_b_s) begin
                    state_b_next_s = SLOT_FULL;
                end else if (b_ready) begin
                    state_b_next_s = SLOT_EMPTY;
                end else begin
                    state_b_next_s = SLOT_FULL;
                end
            end
            default: state_b_next_s = SLOT_EMPTY;
        endcase
    end

    // Slot state, held data and transfer counters; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_a_r <= SLOT_EMPTY;
            state_b_r <= SLOT_EMPTY;
            douta_r   <= {n{1'b0}};
            doutb_r   <= {n{1'b0}};
            cnt_a_r   <= {cw{1'b0}};
            cnt_b_r   <= {cw{1'b0}};
        end else begin
            state_a_r <= state_a_next_s;
            state_b_r <= state_b_next_s;
            // Data registers only load on accept, so a drained slot keeps
            // showing its last word.
            if (acc_a_s) begin
                douta_r <= din;
            end
            if (acc_b_s) begin
                doutb_r <= din;
            end
            if (drain_a_s) begin
                cnt_a_r <= cnt_a_r + {{(cw-1){1'b0}}, 1'b1};
            end
            if (drain_b_s) begin
                cnt_b_r <= cnt_b_r + {{(cw-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready = in_ready_s;
    assign douta    = douta_r;
    assign doutb    = doutb_r;
    assign va       = (state_a_r == SLOT_FULL);
    assign vb       = (state_b_r == SLOT_FULL);
    assign cnt_a    = cnt_a_r;
    assign cnt_b    = cnt_b_r;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream. Stimulus tasks drive inputs just after
// the rising edge and check scenario-specific results inline. A scoreboard
// sampled on the falling edge keeps per-output queues of expected words and
// checks handshake, hold, ordering and counters every cycle.
module tb_demux_stream;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] douta;
    logic       va;
    logic       a_ready;
    logic [3:0] doutb;
    logic       vb;
    logic       b_ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    // Scoreboard model state
    logic       mon_en = 1'b0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] m_douta = 4'h0;
    logic [3:0] m_doutb = 4'h0;
    logic [7:0] m_cnt_a = 8'h00;
    logic [7:0] m_cnt_b = 8'h00;

    demux_stream #(.n(4), .cw(8)) dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .douta(douta), .va(va), .a_ready(a_ready),
        .doutb(doutb), .vb(vb), .b_ready(b_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare DUT with the model, then advance the model to what
    // the coming rising edge must produce.
    always @(negedge clk) begin
        logic exp_rdy;
        if (mon_en) begin
            if (rst) begin
                qa.delete();
                qb.delete();
                m_douta = 4'h0;
                m_doutb = 4'h0;
                m_cnt_a = 8'h00;
                m_cnt_b = 8'h00;
            end else begin
                exp_rdy = sel ? ((qb.size() == 0) || b_ready)
                              : ((qa.size() == 0) || a_ready);
                checks++;
                if (in_ready !== exp_rdy) begin
                    failures++;
                    $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
                end
                checks++;
                if (va !== (qa.size() != 0) || douta !== m_douta) begin
                    failures++;
                    $display("FAIL sb_a: got va=%b douta=%h expected va=%b douta=%h at %0t",
                             va, douta, (qa.size() != 0), m_douta, $time);
                end
                checks++;
                if (vb !== (qb.size() != 0) || doutb !== m_doutb) begin
                    failures++;
                    $display("FAIL sb_b: got vb=%b doutb=%h expected vb=%b doutb=%h at %0t",
                             vb, doutb, (qb.size() != 0), m_doutb, $time);
                end
                checks++;
                if (cnt_a !== m_cnt_a || cnt_b !== m_cnt_b) begin
                    failures++;
                    $display("FAIL sb_cnt: got %0d/%0d expected %0d/%0d at %0t",
                             cnt_a, cnt_b, m_cnt_a, m_cnt_b, $time);
                end
                if (qa.size() != 0 && a_ready) begin
                    void'(qa.pop_front());
                    m_cnt_a = m_cnt_a + 8'd1;
                end
                if (qb.size() != 0 && b_ready) begin
                    void'(qb.pop_front());
                    m_cnt_b = m_cnt_b + 8'd1;
                end
                if (in_valid && exp_rdy) begin
                    if (sel) begin
                        qb.push_back(din);
                        m_doutb = din;
                    end else begin
                        qa.push_back(din);
                        m_douta = din;
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [3:0] d,
                         input logic ar, input logic br);
        in_valid = v;
        sel      = s;
        din      = d;
        a_ready  = ar;
        b_ready  = br;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'hF, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 4'hF, 1'b1, 1'b1);
        checks++;
        if (va !== 1'b0 || vb !== 1'b0 || douta !== 4'h0 || doutb !== 4'h0) begin
            failures++;
            $display("FAIL reset_slots: got va=%b vb=%b douta=%h doutb=%h expected all 0", va, vb, douta, doutb);
        end
        checks++;
        if (cnt_a !== 8'h00 || cnt_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b1);
        checks++;
        if (va !== 1'b1 || douta !== 4'hA) begin
            failures++;
            $display("FAIL basic_a: got va=%b douta=%h expected 1/a", va, douta);
        end
        drive(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        checks++;
        if (vb !== 1'b1 || doutb !== 4'h5 || va !== 1'b0) begin
            failures++;
            $display("FAIL basic_b: got vb=%b doutb=%h va=%b expected 1/5/0", vb, doutb, va);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (cnt_a !== 8'd1 || cnt_b !== 8'd1) begin
            failures++;
            $display("FAIL basic_cnt: got %0d/%0d expected 1/1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
        in_valid = 1'b1;
        sel      = 1'b1;
        din      = 4'h9;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready_b: got %b expected 0", in_ready);
        end
        drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
        checks++;
        if (douta !== 4'h7 || va !== 1'b1 || vb !== 1'b1 || doutb !== 4'h3) begin
            failures++;
            $display("FAIL bp_a7: got douta=%h va=%b doutb=%h vb=%b expected 7/1/3/1", douta, va, doutb, vb);
        end
        drive(1'b1, 1'b0, 4'h8, 1'b1, 1'b0);
        checks++;
        if (douta !== 4'h8 || va !== 1'b1 || cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL bp_a8: got douta=%h va=%b cnt_a=%0d expected 8/1/1", douta, va, cnt_a);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (cnt_a !== 8'd2 || cnt_b !== 8'd0 || vb !== 1'b1 || doutb !== 4'h3) begin
            failures++;
            $display("FAIL bp_hold: got cnt_a=%0d cnt_b=%0d vb=%b doutb=%h expected 2/0/1/3", cnt_a, cnt_b, vb, doutb);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (cnt_b !== 8'd1 || vb !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got cnt_b=%0d vb=%b expected 1/0", cnt_b, vb);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            w = i[3:0];
            drive(1'b1, 1'b0, w, 1'b1, 1'b1);
            checks++;
            if (va !== 1'b1 || douta !== w) begin
                failures++;
                $display("FAIL b2b_word%0d: got va=%b douta=%h expected 1/%h", i, va, douta, w);
            end
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (cnt_a !== 8'd6 || va !== 1'b0) begin
            failures++;
            $display("FAIL b2b_cnt: got cnt_a=%0d va=%b expected 6/0", cnt_a, va);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] w;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = i[3:0];
            drive(1'b1, 1'b1, w, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        checks++;
        if (cnt_b !== 8'd0 || vb !== 1'b0) begin
            failures++;
            $display("FAIL wrap_zero: got cnt_b=%0d vb=%b expected 0/0", cnt_b, vb);
        end
        drive(1'b1, 1'b1, 4'h9, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        checks++;
        if (cnt_b !== 8'd1) begin
            failures++;
            $display("FAIL wrap_one: got cnt_b=%0d expected 1", cnt_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
        checks++;
        if (va !== 1'b1 || vb !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: got va=%b vb=%b expected 1/1", va, vb);
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'hE, 1'b1, 1'b1);
        rst = 1'b0;
        checks++;
        if (va !== 1'b0 || vb !== 1'b0 || douta !== 4'h0 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: got va=%b vb=%b douta=%h cnt=%0d/%0d expected 0/0/0/0/0",
                     va, vb, douta, cnt_a, cnt_b);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (va !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL mid_no_deliver: got va=%b cnt_a=%0d expected 0/0", va, cnt_a);
        end
    endtask

    initial begin
        rst      = 1'b1;
        din      = 4'h0;
        sel      = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
